// File: rtl/dot4_mac_pkg.sv
// dot4_mac_pkg
// Shared definitions for the dot4_mac multiply-accumulate stage:
//   - out_state_e : output-register FSM states (ACCUM = no result held,
//                   FULL = result held on acc_out awaiting out_ready)
//   - OPND_W/PROD_W : operand and product widths of the 4x4 multiplier
//   - cnt_width()   : element-counter width for a given vector length
package dot4_mac_pkg;

    localparam int OPND_W = 4;
    localparam int PROD_W = 8;

    typedef enum logic {
        ACCUM = 1'b0,
        FULL  = 1'b1
    } out_state_e;

    // $clog2(LEN), but never narrower than one bit.
    function automatic int cnt_width(input int len);
        int w;
        w = $clog2(len);
        return (w < 1) ? 1 : w;
    endfunction

endpackage

// File: rtl/dot4_mac_mul.sv
// mul
// Combinational 4x4 unsigned array multiplier: z = x * y.
// Ports:
//   x [3:0] in   multiplicand
//   y [3:0] in   multiplier
//   z [7:0] out  product (max 225)
module mul
    import dot4_mac_pkg::*;
(
    input  logic [OPND_W-1:0] x,
    input  logic [OPND_W-1:0] y,
    output logic [PROD_W-1:0] z
);

    // Shift-and-add over the multiplier bits: one partial-product row per bit.
    always_comb begin
        z = '0;
        for (int i = 0; i < OPND_W; i++) begin
            if (y[i]) begin
                z = z + ({{(PROD_W-OPND_W){1'b0}}, x} << i);
            end
        end
    end

endmodule

// File: rtl/dot4_mac.sv
// dot4_mac
// Sequential multiply-accumulate stage. Accepts 4-bit operand pairs, registers
// each 8-bit product (stage 1), sums LEN consecutive products (stage 2) and
// presents the dot product on a held output register.
//
// Parameters:
//   LEN   products per result, 2..256
//   ACC_W accumulator / result width, >= 8
// Ports:
//   clk          in   rising-edge clock
//   rst_n        in   asynchronous active-low reset
//   in_valid     in   operand pair present
//   in_ready     out  pair accepted this cycle (when in_valid also high)
//   x, y [3:0]   in   unsigned operands
//   out_valid    out  result held on acc_out / out_ovf
//   out_ready    in   downstream takes the result this cycle
//   acc_out      out  dot-product result
//   out_ovf      out  accumulation of this result carried out of ACC_W bits
//   dbg_state_o  out  output FSM state (ACCUM / FULL)
//
// Handshakes: a transfer happens on a rising edge where valid && ready are
// both high. The producer holds its data stable while valid is high and ready
// is low; ready may depend combinationally on the other side (in_ready follows
// out_ready in the same cycle).
//
// Optional feature macro: DOT4_MAC_SAT_EN -- when defined, an overflowing
// vector saturates to 2^ACC_W-1 instead of wrapping.
module dot4_mac
    import dot4_mac_pkg::*;
#(
    parameter int LEN   = 4,
    parameter int ACC_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [OPND_W-1:0] x,
    input  logic [OPND_W-1:0] y,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [ACC_W-1:0]  acc_out,
    output logic              out_ovf,
    output out_state_e        dbg_state_o
);

    localparam int               CNT_W    = cnt_width(LEN);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LEN - 1);
    localparam logic [ACC_W-1:0] ACC_MAX  = '1;

    // Stage 1: product register
    logic [PROD_W-1:0] prod_d;
    logic [PROD_W-1:0] p_q;
    logic              p_vld_q;
    logic              accept;

    // Stage 2: accumulator
    logic [ACC_W-1:0]  acc_q;
    logic [ACC_W-1:0]  acc_d;
    logic              ovf_acc_q;
    logic              ovf_d;
    logic [CNT_W-1:0]  cnt_q;
    logic [CNT_W-1:0]  cnt_d;
    logic [ACC_W:0]    sum;
    logic [ACC_W-1:0]  acc_base;
    logic              ovf_base;
    logic              last_elem;

    // Output register / FSM
    out_state_e        state_q;
    logic [ACC_W-1:0]  acc_out_q;
    logic              out_ovf_q;

    assign out_valid   = (state_q == FULL);
    assign in_ready    = !out_valid || out_ready;
    assign accept      = in_valid && in_ready;
    assign acc_out     = acc_out_q;
    assign out_ovf     = out_ovf_q;
    assign dbg_state_o = state_q;

    mul u_mul (
        .x (x),
        .y (y),
        .z (prod_d)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p_q     <= '0;
            p_vld_q <= 1'b0;
        end else begin
            p_vld_q <= accept;
            if (accept) begin
                p_q <= prod_d;
            end
        end
    end

    // cnt==0 marks the first element of a vector: it starts from zero instead
    // of the previous vector's total, so no separate clear cycle is needed.
    always_comb begin
        acc_base  = (cnt_q == '0) ? '0 : acc_q;
        ovf_base  = (cnt_q == '0) ? 1'b0 : ovf_acc_q;
        sum       = {1'b0, acc_base} + {{(ACC_W+1-PROD_W){1'b0}}, p_q};
        ovf_d     = ovf_base | sum[ACC_W];
`ifdef DOT4_MAC_SAT_EN
        // The sticky overflow keeps the value pinned at full scale for the
        // rest of the vector.
        acc_d     = ovf_d ? ACC_MAX : sum[ACC_W-1:0];
`else
        acc_d     = sum[ACC_W-1:0];
`endif
        last_elem = p_vld_q && (cnt_q == CNT_LAST);
        cnt_d     = last_elem ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q     <= '0;
            ovf_acc_q <= 1'b0;
            cnt_q     <= '0;
        end else if (p_vld_q) begin
            acc_q     <= acc_d;
            ovf_acc_q <= ovf_d;
            cnt_q     <= cnt_d;
        end
    end

    // A product already in stage 1 when FULL is entered keeps draining into
    // the accumulator; with LEN >= 2 it can never be a last element, so the
    // held result is never overwritten before it is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= ACCUM;
            acc_out_q <= '0;
            out_ovf_q <= 1'b0;
        end else begin
            case (state_q)
                ACCUM: begin
                    if (last_elem) begin
                        acc_out_q <= acc_d;
                        out_ovf_q <= ovf_d;
                        state_q   <= FULL;
                    end
                end
                FULL: begin
                    if (out_ready) begin
                        if (last_elem) begin
                            acc_out_q <= acc_d;
                            out_ovf_q <= ovf_d;
                        end else begin
                            state_q   <= ACCUM;
                        end
                    end
                end
                default: state_q <= ACCUM;
            endcase
        end
    end

endmodule
